upe_mul_magsign32: RTL and testbench
====================================

# upe_mul_magsign32

Sequential 32×32 signed multiplier. It splits two's-complement operands into magnitude and sign, forms the 64-bit unsigned product magnitude by shift-and-add over 32 cycles, and reports the product sign separately. It sits directly upstream of `upe_resign64u`: `mag` drives its `In` and `sign` drives its `sign`. This keeps the wide multiply off the critical path on the iCE40 at the cost of fixed multi-cycle latency.

## Interface
Parameters: none (widths fixed at 32-bit operands, 64-bit magnitude).

Ports:
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply; sampled only when `busy`=0.
- `a` in 32: operand A, two's complement; captured when `start` is accepted.
- `b` in 32: operand B, two's complement; captured when `start` is accepted.
- `busy` out 1: high from start acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse; `mag`/`sign` hold the new result.
- `mag` out 64: unsigned |a|·|b|.
- `sign` out 1: product sign, 1 = negative.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: 32 iterations, counter 0..31.
  - DONE: single cycle.
- IDLE, `start`=1 at an edge: capture the operands and go to RUN.
  - M (64-bit) ← zero-extended |a|; Q (32-bit) ← |b|; P (64-bit) ← 0; counter ← 0.
  - Sign register ← a[31]^b[31], forced to 0 if a==0 or b==0. No negative zero is ever produced.
- Magnitude is the 32-bit two's negate when the MSB is set, else the operand unchanged.
  - |0x80000000| = 0x80000000, interpreted unsigned as 2^31. No overflow case exists.
- Each RUN edge:
  - if Q[0], then P ← P + M (64-bit, cannot overflow);
  - M ← M<<1; Q ← Q>>1; counter ← counter+1.
  - After the edge that processes counter=31, go to DONE.
- No early termination. Latency is identical for all operands, including zero.
- On the RUN→DONE edge: `mag` ← final P and `sign` ← sign register, together.
  - `mag`/`sign` are output registers, held stable until the next RUN→DONE edge.
  - They do not change during a later RUN.
- DONE: `done`=1, `busy`=1. Next edge returns to IDLE unconditionally.
- `start` while `busy`=1 (RUN or DONE): ignored, with no queueing. `a`/`b` changes during RUN have no effect.
- Reset (any state, including mid-RUN): state → IDLE, counter/P/M/Q cleared, `busy`=0, `done`=0, `mag`=0, `sign`=0.
  - The in-flight operation is discarded. `start` asserted together with `reset` is ignored.

## Timing
- Output reset values: `busy`=0, `done`=0, `mag`=64'h0, `sign`=0.
- `start` accepted at edge t:
  - `busy`=1 from after edge t;
  - RUN edges t+1..t+32;
  - `done`=1 and the new `mag`/`sign` visible after edge t+32;
  - `done`=0 and `busy`=0 after edge t+33.
- Latency from accepting edge to result: 32 cycles. Minimum start-to-start interval: 34 cycles (next accept at edge t+34, while `busy`=0).
- `start` held high continuously: a new operation is accepted every 34 cycles. Each result pulses `done` once.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- a=3, b=5, start 1 cycle → `done` after 32 cycles of RUN (33 edges after start) with `mag`=64'd15, `sign`=0; `busy` high exactly 33 cycles.
- a=-7 (0xFFFFFFF9), b=6 → `mag`=64'd42, `sign`=1. Feeding `upe_resign64u` yields the expected signed value.
- a=b=0x80000000 → `mag`=64'h4000000000000000, `sign`=0. a=0x80000000, b=0x7FFFFFFF → `mag`=64'h3FFFFFFF80000000, `sign`=1.
- a=0, b=-5 → `mag`=0, `sign`=0 (no negative zero). a=0xFFFFFFFF, b=0xFFFFFFFF → `mag`=1, `sign`=0.
- Pulse `start` with a=9, b=9, then `start` with a=2, b=2 at RUN cycle 10 → single `done`, `mag`=81; prior `mag` held unchanged throughout RUN.
- Assert `reset` at RUN cycle 17 → next cycle: `busy`=0, `done`=0, `mag`=0, `sign`=0, no `done` pulse ever appears. A following start with a=4, b=-4 gives `mag`=16, `sign`=1 with normal latency.

Source files
------------

// File: rtl/upe_mul_magsign32_if.sv
// Handshake and operand/result bundle for the sequential magnitude/sign multiplier.
// The requester drives start/a/b; the multiplier returns busy/done/mag/sign.
interface upe_mul_magsign32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] mag;
  logic        sign;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  mag,
    input  sign
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output mag,
    output sign
  );
endinterface

// File: rtl/upe_mul_magsign32.sv
// Sequential 32x32 signed multiplier that returns the product as a 64-bit unsigned
// magnitude plus a separate sign. The latency is a fixed 32-cycle shift-and-add.
module upe_mul_magsign32 (
  input  logic               clk,
  input  logic               reset,
  upe_mul_magsign32_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [63:0] r_p;
  logic [63:0] r_m;
  logic [31:0] r_q;
  logic        r_sgn;
  logic [63:0] r_mag;
  logic        r_sign;
  logic        w_accept;
  logic        w_last;
  logic [63:0] w_p_nxt;
  logic        w_busy;
  logic        w_done;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 when read unsigned.
  function automatic logic [31:0] f_mag(input logic signed [31:0] x);
    logic [31:0] r;
    if (x[31]) r = ~x + 32'd1;
    else       r = x;
    return r;
  endfunction

  // A zero operand always gives a positive result, so there is no negative zero.
  function automatic logic f_sign(input logic signed [31:0] x, input logic signed [31:0] y);
    logic r;
    if ((x == 32'sd0) || (y == 32'sd0)) r = 1'b0;
    else                                r = x[31] ^ y[31];
    return r;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == 5'd31);
  assign w_p_nxt  = r_q[0] ? (r_p + r_m) : r_p;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then one add/shift per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_p    <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_sgn  <= 1'b0;
      r_mag  <= '0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_m   <= {32'h0, f_mag(bus.a)};
      r_q   <= f_mag(bus.b);
      r_p   <= '0;
      r_cnt <= '0;
      r_sgn <= f_sign(bus.a, bus.b);
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_nxt;
      r_m   <= {r_m[62:0], 1'b0};
      r_q   <= {1'b0, r_q[31:1]};
      r_cnt <= r_cnt + 5'd1;
      if (w_last) begin
        r_mag  <= w_p_nxt;
        r_sign <= r_sgn;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.mag  = r_mag;
  assign bus.sign = r_sign;

endmodule

// File: tb/tb_upe_mul_magsign32.sv
// Self-checking bench for upe_mul_magsign32: directed corner cases plus random
// operands compared against a plain signed-arithmetic reference.
module tb_upe_mul_magsign32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [63:0] held_mag = 64'h0;
  logic        held_sign = 1'b0;

  always #5 clk = ~clk;

  upe_mul_magsign32_if bus ();

  upe_mul_magsign32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full signed product in 64-bit arithmetic, then split.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] m, output logic s);
    longint sa, sb, pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pr = sa * sb;
    s  = (pr < 0);
    m  = s ? 64'(-pr) : 64'(pr);
  endtask

  // One operation from IDLE; optional ignored start pulse at RUN cycle poke_at.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input int poke_at);
    logic [63:0] em;
    logic        es;
    ref_mul(a, b, em, es);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("done_after_accept", 64'(bus.done), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      if (i == poke_at) begin
        bus.a = 32'd2;
        bus.b = 32'd2;
        bus.start = 1'b1;
      end else begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      tick();
      bus.start = 1'b0;
      chk("busy_run", 64'(bus.busy), 64'd1);
      if (i < 32) begin
        chk("done_early", 64'(bus.done), 64'd0);
        chk("mag_held", bus.mag, held_mag);
        chk("sign_held", 64'(bus.sign), 64'(held_sign));
      end else begin
        chk("done_pulse", 64'(bus.done), 64'd1);
        chk("mag", bus.mag, em);
        chk("sign", 64'(bus.sign), 64'(es));
      end
    end
    tick();
    chk("done_clear", 64'(bus.done), 64'd0);
    chk("busy_clear", 64'(bus.busy), 64'd0);
    chk("mag_stable", bus.mag, em);
    held_mag  = em;
    held_sign = es;
    tick();
    chk("no_requeue", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] em;
    logic        es;
    int          seen;
    int          first_at;
    int          second_at;

    reset = 1'b1;
    bus.start = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd5;
    tick();
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mag", bus.mag, 64'h0);
    chk("rst_sign", 64'(bus.sign), 64'd0);
    tick();
    chk("start_with_reset_ignored", 64'(bus.busy), 64'd0);

    op(32'd3, 32'd5, 0);
    chk("dir_3x5", held_mag, 64'd15);
    op(32'hFFFFFFF9, 32'd6, 0);
    chk("dir_m7x6", {held_mag[62:0], held_sign}, {63'd42, 1'b1});
    op(32'h80000000, 32'h80000000, 0);
    chk("dir_min_sq", held_mag, 64'h4000000000000000);
    op(32'h80000000, 32'h7FFFFFFF, 0);
    chk("dir_min_max", {held_mag[62:0], held_sign}, {63'h3FFFFFFF80000000, 1'b1});
    op(32'd0, 32'hFFFFFFFB, 0);
    chk("dir_zero_sign", 64'(held_sign), 64'd0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("dir_m1_sq", held_mag, 64'd1);
    op(32'd9, 32'd9, 10);
    chk("dir_poke_ignored", held_mag, 64'd81);

    for (int k = 0; k < 12; k++) begin
      op($urandom, $urandom, (k % 3 == 0) ? int'($urandom_range(1, 32)) : 0);
    end

    // Reset mid-RUN discards the operation.
    bus.a = 32'd100;
    bus.b = 32'hFFFFFFFD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_mag", bus.mag, 64'h0);
    chk("midrst_sign", 64'(bus.sign), 64'd0);
    held_mag = 64'h0;
    held_sign = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    op(32'd4, 32'hFFFFFFFC, 0);
    chk("after_rst_4xm4", {held_mag[62:0], held_sign}, {63'd16, 1'b1});

    // Start held high: accepts every 34 cycles, one done per result.
    bus.a = $urandom;
    bus.b = $urandom;
    ref_mul(bus.a, bus.b, em, es);
    bus.start = 1'b1;
    seen = 0;
    first_at = -1;
    second_at = -1;
    for (int k = 0; k < 68; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        seen++;
        if (first_at < 0) first_at = k;
        else second_at = k;
        chk("held_start_mag", bus.mag, em);
        chk("held_start_sign", 64'(bus.sign), 64'(es));
      end
    end
    bus.start = 1'b0;
    chk("held_start_count", 64'(seen), 64'd2);
    chk("held_start_first", 64'(first_at), 64'd32);
    chk("held_start_second", 64'(second_at), 64'd66);
    tick();
    chk("held_start_idle", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
